// File: rtl/rsa_decoder_pkg.sv
// Shared constants and state type for the RSA decoder and its modular multiplier.
package rsa_decoder_pkg;

  localparam int unsigned WORD_W   = 8;
  localparam int unsigned MM_ITERS = 8;
  localparam int unsigned MM_IDX_W = $clog2(MM_ITERS);
  localparam int unsigned EXP_IDX_W = $clog2(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n over MM_ITERS cycles.
module rsa_modmul
  import rsa_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] n,
  output logic [WORD_W-1:0] p,
  output logic              rdy
);

  logic [WORD_W-1:0]   acc_q;
  logic [WORD_W-1:0]   acc_in;
  logic [WORD_W-1:0]   acc_nxt;
  logic [MM_IDX_W-1:0] idx_q;
  logic [MM_IDX_W-1:0] idx;
  logic                active_q;
  logic [WORD_W:0]     dbl;
  logic [WORD_W:0]     sum;

  // go performs the first (MSB) step in its own cycle, so the final step's
  // combinational result is presented on p together with rdy.
  always_comb begin
    acc_in = go ? '0 : acc_q;
    idx    = go ? MM_IDX_W'(MM_ITERS - 1) : idx_q;
    dbl    = {acc_in, 1'b0};
    if (dbl >= {1'b0, n}) dbl = dbl - {1'b0, n};
    sum = dbl + (b[idx] ? {1'b0, a} : '0);
    if (sum >= {1'b0, n}) sum = sum - {1'b0, n};
    acc_nxt = sum[WORD_W-1:0];
  end

  assign p   = acc_nxt;
  assign rdy = (go || active_q) && (idx == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (go || active_q) begin
      acc_q    <= acc_nxt;
      idx_q    <= idx - MM_IDX_W'(1);
      active_q <= (idx != '0);
    end
  end

endmodule

// File: rtl/rsa_decoder.sv
// RSA decoder: m = c^d mod n by left-to-right constant-time square-and-multiply.
module rsa_decoder
  import rsa_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] d,
  input  logic [WORD_W-1:0] n,
  output logic [WORD_W-1:0] m,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t               state_q;
  state_t               state_d;
  logic [WORD_W-1:0]    c_q;
  logic [WORD_W-1:0]    d_q;
  logic [WORD_W-1:0]    n_q;
  logic [WORD_W-1:0]    r_q;
  logic [EXP_IDX_W-1:0] bit_q;
  logic                 launch_q;
  logic                 accept;
  logic                 invalid;
  logic [WORD_W-1:0]    mm_b;
  logic [WORD_W-1:0]    mm_p;
  logic                 mm_rdy;

  // done is registered and lands in IDLE, so a start coincident with it is masked.
  assign accept  = (state_q == S_IDLE) && start && !done;
  assign invalid = (n_q < WORD_W'(2)) || (c_q >= n_q);
  assign mm_b    = (state_q == S_SQR) ? r_q : c_q;

  rsa_modmul u_modmul (
    .clk   (clk),
    .reset (reset),
    .go    (launch_q),
    .a     (r_q),
    .b     (mm_b),
    .n     (n_q),
    .p     (mm_p),
    .rdy   (mm_rdy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CHECK;
      S_CHECK: state_d = invalid ? S_DONE : S_SQR;
      S_SQR:   if (mm_rdy) state_d = S_MUL;
      S_MUL:   if (mm_rdy) state_d = (bit_q == '0) ? S_DONE : S_SQR;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q      <= '0;
      d_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      bit_q    <= '0;
      launch_q <= 1'b0;
      m        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      launch_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          c_q  <= c;
          d_q  <= d;
          n_q  <= n;
          err  <= 1'b0;
          busy <= 1'b1;
        end
        S_CHECK: if (invalid) begin
          r_q <= '0;
        end else begin
          r_q      <= WORD_W'(1);
          bit_q    <= EXP_IDX_W'(WORD_W - 1);
          launch_q <= 1'b1;
        end
        S_SQR: if (mm_rdy) begin
          r_q      <= mm_p;
          launch_q <= 1'b1;
        end
        S_MUL: if (mm_rdy) begin
          if (d_q[bit_q]) r_q <= mm_p;
          if (bit_q != '0) begin
            bit_q    <= bit_q - EXP_IDX_W'(1);
            launch_q <= 1'b1;
          end
        end
        S_DONE: begin
          m    <= invalid ? '0 : r_q;
          err  <= invalid;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decoder.sv
// Self-checking bench for rsa_decoder against an arithmetic modular-exponentiation model.
module tb_rsa_decoder;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] c;
  logic [7:0] d;
  logic [7:0] n;
  logic [7:0] m;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int failures;

  rsa_decoder dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .c     (c),
    .d     (d),
    .n     (n),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int modexp(input int base, input int e, input int md);
    int r;
    r = 1 % md;
    for (int i = 0; i < e; i++) r = (r * base) % md;
    return r;
  endfunction

  function automatic int gcd(input int x, input int y);
    int a0, b0, t;
    a0 = x; b0 = y;
    while (b0 != 0) begin t = a0 % b0; a0 = b0; b0 = t; end
    return a0;
  endfunction

  // Expected result of one decode from the operand-validity rule and c^d mod n.
  task automatic expect_of(input int ci, input int di, input int ni,
                           output int me, output int ee, output int le);
    if (ni < 2 || ci >= ni) begin me = 0; ee = 1; le = 2; end
    else begin me = modexp(ci, di, ni); ee = 0; le = 130; end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_decode(input logic [7:0] ci, input logic [7:0] di, input logic [7:0] ni,
                            output logic [7:0] mo, output logic eo, output int lat);
    @(negedge clk);
    c = ci; d = di; n = ni; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    mo = m;
    eo = err;
  endtask

  task automatic check_decode(input string name, input int ci, input int di, input int ni);
    logic [7:0] mo;
    logic       eo;
    int         lat, me, ee, le;
    expect_of(ci, di, ni, me, ee, le);
    run_decode(8'(ci), 8'(di), 8'(ni), mo, eo, lat);
    checks += 3;
    if (mo !== 8'(me)) begin failures++; $display("FAIL %s m: got %0d want %0d", name, mo, me); end
    if (eo !== 1'(ee)) begin failures++; $display("FAIL %s err: got %0b want %0d", name, eo, ee); end
    if (lat != le) begin failures++; $display("FAIL %s latency: got %0d want %0d", name, lat, le); end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; c = '0; d = '0; n = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (m !== 8'd0)   begin failures++; $display("FAIL reset m: got %0d want 0", m); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %0b want 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset done: got %0b want 0", done); end
    if (err !== 1'b0)  begin failures++; $display("FAIL reset err: got %0b want 0", err); end
    reset = 1'b1;
  endtask

  task automatic test_known_vectors;
    check_decode("n33_c31_d7", 31, 7, 33);
    check_decode("n33_c5_d0", 5, 0, 33);
    check_decode("n33_c0_d9", 0, 9, 33);
    check_decode("err_c_eq_n", 143, 5, 143);
    check_decode("err_n1", 0, 3, 1);
    check_decode("n143_c142_d255", 142, 255, 143);
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    c = 8'd48; d = 8'd103; n = 8'd143; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    c = 8'd5; d = 8'd3; n = 8'd33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    lat = 22;
    while (done !== 1'b1 && lat < 300) begin @(posedge clk); lat++; @(negedge clk); end
    checks += 3;
    if (m !== 8'd9) begin failures++; $display("FAIL busy_ignore m: got %0d want 9", m); end
    if (err !== 1'b0) begin failures++; $display("FAIL busy_ignore err: got %0b want 0", err); end
    if (lat != 130) begin failures++; $display("FAIL busy_ignore latency: got %0d want 130", lat); end
    repeat (5) @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_ignore no_restart busy: got %0b want 0", busy); end
    if (m !== 8'd9) begin failures++; $display("FAIL busy_ignore hold m: got %0d want 9", m); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    c = 8'd31; d = 8'd7; n = 8'd33; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(lat);
    c = 8'd4; d = 8'd3; n = 8'd33;
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b start_with_done busy: got %0b want 0", busy); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b accept_next busy: got %0b want 1", busy); end
    wait_done(lat);
    checks += 2;
    if (m !== 8'(modexp(4, 3, 33))) begin failures++; $display("FAIL b2b m: got %0d want %0d", m, modexp(4, 3, 33)); end
    if (lat != 130) begin failures++; $display("FAIL b2b latency: got %0d want 130", lat); end
  endtask

  task automatic test_reset_abort;
    int seen_done;
    @(negedge clk);
    c = 8'd48; d = 8'd103; n = 8'd143; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort busy: got %0b want 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL abort done: got %0b want 0", done); end
    if (m !== 8'd0)    begin failures++; $display("FAIL abort m: got %0d want 0", m); end
    if (err !== 1'b0)  begin failures++; $display("FAIL abort err: got %0b want 0", err); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen_done = 0;
    repeat (150) begin @(negedge clk); if (done === 1'b1) seen_done++; end
    checks++;
    if (seen_done != 0) begin failures++; $display("FAIL abort spurious_done: got %0d want 0", seen_done); end
    check_decode("after_abort", 31, 7, 33);
  endtask

  task automatic test_random_rsa;
    int primes[6] = '{2, 3, 5, 7, 11, 13};
    int p, q, nn, phi, e, dd, msg, ct, lat;
    logic [7:0] mo;
    logic       eo;
    for (int it = 0; it < 20; it++) begin
      p = primes[$urandom_range(5, 0)];
      do q = primes[$urandom_range(5, 0)]; while (q == p);
      nn  = p * q;
      phi = (p - 1) * (q - 1);
      do e = $urandom_range(phi, 1); while (gcd(e, phi) != 1);
      dd = 1;
      while (((e * dd) % phi) != (1 % phi)) dd++;
      msg = $urandom_range(nn - 1, 0);
      ct  = modexp(msg, e, nn);
      run_decode(8'(ct), 8'(dd), 8'(nn), mo, eo, lat);
      checks += 3;
      if (mo !== 8'(msg)) begin failures++; $display("FAIL rand%0d m: got %0d want %0d (n=%0d c=%0d d=%0d)", it, mo, msg, nn, ct, dd); end
      if (eo !== 1'b0) begin failures++; $display("FAIL rand%0d err: got %0b want 0", it, eo); end
      if (lat != 130) begin failures++; $display("FAIL rand%0d latency: got %0d want 130", it, lat); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_known_vectors;
    test_start_while_busy;
    test_back_to_back;
    test_reset_abort;
    test_random_rsa;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
